if_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipelined MIPS-subset processor, directly upstream of `ID_stage`. It owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register that supplies `instruction` to decode. It resolves redirects raised in ID (taken branch, jump), honours the hazard stall, and runs a halt/drain state machine after `terminate` so downstream stages can retire before `done` is raised.

---
 rtl/if_stage.sv | 136 +++++++++++++
 tb/tb_if_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch: PC, IF/ID register, ID-resolved redirects, hazard stall, halt/drain FSM.
// imem_addr is combinational from pc; every other output is registered (1-cycle fetch-to-ID).
module if_stage #(
    parameter int              WORD         = 32,
    parameter logic [WORD-1:0] RESET_PC     = '0,
    parameter int              DRAIN_CYCLES = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_branch_taken,
    input  logic            i_jump_taken,
    input  logic [WORD-1:0] i_branch_offset,
    input  logic [WORD-1:0] i_jump_address,
    input  logic            i_terminate,
    input  logic [WORD-1:0] i_imem_data,
    output logic [WORD-1:0] o_imem_addr,
    output logic [WORD-1:0] o_instruction,
    output logic [WORD-1:0] o_pc_plus4_id,
    output logic [WORD-1:0] o_fetch_count,
    output logic            o_done
);

    localparam int            CW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t          r_state;
    logic [WORD-1:0] r_pc;
    logic [WORD-1:0] r_instr;
    logic [WORD-1:0] r_pc4;
    logic            r_valid_id;
    logic [CW-1:0]   r_drain_cnt;
    logic [WORD-1:0] r_fetch_count;
    logic            r_done;

    state_t          w_state_nxt;
    logic [WORD-1:0] w_pc_nxt;
    logic [WORD-1:0] w_instr_nxt;
    logic [WORD-1:0] w_pc4_nxt;
    logic            w_valid_nxt;
    logic [CW-1:0]   w_drain_cnt_nxt;
    logic [WORD-1:0] w_fetch_count_nxt;

    logic [WORD-1:0] w_seq_pc;
    logic [WORD-1:0] w_jump_tgt;
    logic [WORD-1:0] w_branch_tgt;
    logic            w_unused;

    assign w_seq_pc     = r_pc + WORD'(4);
    // Jump keeps the region bits of the instruction in ID, not of the fetch PC.
    assign w_jump_tgt   = {r_pc4[WORD-1:WORD-4], i_jump_address[25:0], 2'b00};
    assign w_branch_tgt = r_pc4 + {i_branch_offset[WORD-3:0], 2'b00};
    assign w_unused     = ^{i_jump_address[WORD-1:26], i_branch_offset[WORD-1:WORD-2], r_valid_id};

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_pc4_nxt         = r_pc4;
        w_valid_nxt       = r_valid_id;
        w_drain_cnt_nxt   = r_drain_cnt;
        w_fetch_count_nxt = r_fetch_count;
        case (r_state)
            S_RUN: begin
                // Under stall ID re-presents redirect/terminate afterwards, so ignore them now.
                if (!i_stall) begin
                    if (i_terminate) begin
                        w_state_nxt     = S_DRAIN;
                        w_instr_nxt     = '0;
                        w_valid_nxt     = 1'b0;
                        w_drain_cnt_nxt = '0;
                    end else if (i_jump_taken || i_branch_taken) begin
                        w_pc_nxt    = i_jump_taken ? w_jump_tgt : w_branch_tgt;
                        w_instr_nxt = '0;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_pc_nxt          = w_seq_pc;
                        w_instr_nxt       = i_imem_data;
                        w_pc4_nxt         = w_seq_pc;
                        w_valid_nxt       = 1'b1;
                        w_fetch_count_nxt = r_fetch_count + WORD'(1);
                    end
                end
            end
            S_DRAIN: begin
                w_instr_nxt     = '0;
                w_valid_nxt     = 1'b0;
                w_drain_cnt_nxt = r_drain_cnt + CW'(1);
                if (r_drain_cnt == LAST) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_pc4         <= '0;
            r_valid_id    <= 1'b0;
            r_drain_cnt   <= '0;
            r_fetch_count <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_pc4         <= w_pc4_nxt;
            r_valid_id    <= w_valid_nxt;
            r_drain_cnt   <= w_drain_cnt_nxt;
            r_fetch_count <= w_fetch_count_nxt;
            // One edge behind HALTED so done lands DRAIN_CYCLES+1 edges after terminate.
            r_done        <= (r_state == S_HALTED);
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_instruction = r_instr;
    assign o_pc_plus4_id = r_pc4;
    assign o_fetch_count = r_fetch_count;
    assign o_done        = r_done;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, redirects, stall, PC wrap, terminate/drain, reset mid-drain.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic        jump_taken;
    logic [31:0] branch_offset;
    logic [31:0] jump_address;
    logic        terminate;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] instruction;
    logic [31:0] pc_plus4_id;
    logic [31:0] fetch_count;
    logic        done;

    logic [31:0] mem [64];
    int n_pass;
    int n_total;

    if_stage dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall        (stall),
        .i_branch_taken (branch_taken),
        .i_jump_taken   (jump_taken),
        .i_branch_offset(branch_offset),
        .i_jump_address (jump_address),
        .i_terminate    (terminate),
        .i_imem_data    (imem_data),
        .o_imem_addr    (imem_addr),
        .o_instruction  (instruction),
        .o_pc_plus4_id  (pc_plus4_id),
        .o_fetch_count  (fetch_count),
        .o_done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:2]];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag, input logic [31:0] a, input logic [31:0] ins,
                             input logic [31:0] fc);
        chk({tag, ".addr"}, imem_addr, a);
        chk({tag, ".instr"}, instruction, ins);
        chk({tag, ".fcnt"}, fetch_count, fc);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | (i << 2);
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_0003;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
        branch_offset = '0; jump_address = '0; terminate = 1'b0;

        // Reset
        step(); step();
        chk_state("reset", 32'h0, 32'h0, 32'h0);
        chk("reset.pc4", pc_plus4_id, 32'h0);
        chk("reset.done", {31'b0, done}, 32'h0);
        rst = 1'b0;

        // Straight-line fetch
        step(); chk_state("seq1", 32'h4, 32'h2001_0005, 32'd1);
        chk("seq1.pc4", pc_plus4_id, 32'h4);
        step(); chk_state("seq2", 32'h8, 32'h2002_0003, 32'd2);
        step(); chk_state("seq3", 32'hC, 32'hA000_0008, 32'd3);
        step(); chk_state("seq4", 32'h10, 32'hA000_000C, 32'd4);
        chk("seq4.pc4", pc_plus4_id, 32'h10);

        // Backward branch: 0x10 + (-2 << 2) = 0x08
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
        step(); chk_state("br", 32'h8, 32'h0, 32'd4);
        branch_taken = 1'b0;
        step(); chk_state("br.after", 32'hC, 32'hA000_0008, 32'd5);

        // Jump beats branch; upper jump_address bits are ignored
        jump_taken = 1'b1; jump_address = 32'hFC00_0040;
        branch_taken = 1'b1; branch_offset = 32'h0000_0010;
        step(); chk_state("jmp", 32'h100, 32'h0, 32'd5);
        jump_taken = 1'b0; branch_taken = 1'b0;
        step(); chk_state("jmp.after", 32'h104, 32'h2001_0005, 32'd6);
        chk("jmp.pc4", pc_plus4_id, 32'h104);

        // Stall holds everything and ignores the redirect
        stall = 1'b1; branch_taken = 1'b1; branch_offset = 32'h4;
        for (int i = 0; i < 3; i++) begin
            step(); chk_state("stall", 32'h104, 32'h2001_0005, 32'd6);
        end
        stall = 1'b0;
        step(); chk_state("stall.redir", 32'h114, 32'h0, 32'd6);

        // Branch to 0xFFFFFFFC, then PC+4 wraps to 0
        branch_offset = 32'hFFFF_FFBE;
        step(); chk_state("wrap.br", 32'hFFFF_FFFC, 32'h0, 32'd6);
        branch_taken = 1'b0;
        step(); chk_state("wrap", 32'h0, 32'hA000_00FC, 32'd7);
        chk("wrap.pc4", pc_plus4_id, 32'h0);

        // Jump to 0x20
        jump_taken = 1'b1; jump_address = 32'h8;
        step(); chk_state("jmp20", 32'h20, 32'h0, 32'd7);
        jump_taken = 1'b0;

        // Terminate wins over simultaneous branch; drain ignores inputs
        terminate = 1'b1; branch_taken = 1'b1;
        step(); chk_state("term", 32'h20, 32'h0, 32'd7);
        chk("term.done", {31'b0, done}, 32'h0);
        terminate = 1'b0; branch_taken = 1'b0; jump_taken = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(); chk_state("drain", 32'h20, 32'h0, 32'd7);
            chk("drain.done", {31'b0, done}, 32'h0);
        end
        jump_taken = 1'b0;
        step(); chk("done.edge5", {31'b0, done}, 32'h1);
        chk_state("halted", 32'h20, 32'h0, 32'd7);
        step(); chk("done.hold", {31'b0, done}, 32'h1);

        // Fresh run, then reset two cycles into DRAIN
        rst = 1'b1;
        step(); chk("rst2.done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        step(); chk_state("rst2.run", 32'h4, 32'h2001_0005, 32'd1);
        terminate = 1'b1;
        step(); terminate = 1'b0;
        step(); step();
        chk("mid.addr", imem_addr, 32'h4);
        rst = 1'b1;
        step(); chk_state("mid.rst", 32'h0, 32'h0, 32'h0);
        chk("mid.done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        step(); chk_state("mid.resume", 32'h4, 32'h2001_0005, 32'd1);
        step(); chk_state("mid.resume2", 32'h8, 32'h2002_0003, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
